// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared constants, machine modes and reader state enum for the vote tally reader
package vote_pkg;
  localparam int NUM_CAND  = 4;
  localparam int VOTE_W    = 32;
  localparam int FRAME_LEN = 19;

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_VOTE    = 2'b01;
  localparam logic [1:0] MODE_RESET   = 2'b10;
  localparam logic [1:0] MODE_DISPLAY = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    COMPARE = 2'b10,
    SEND    = 2'b11
  } reader_state_e;
endpackage

// File: rtl/tally_frame_mux.sv
// rtl/tally_frame_mux.sv - combinational frame byte selector: sync, tallies MSB first, winner, checksum
module tally_frame_mux
  import vote_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic [NUM_CAND*VOTE_W-1:0] snap_i,
  input  logic [2:0]                 winner_i,
  input  logic [7:0]                 csum_i,
  input  logic [4:0]                 idx_i,
  output logic [7:0]                 byte_o
);

  logic [3:0] pos;

  always_comb begin
    byte_o = 8'h00;
    pos    = 4'(idx_i - 5'd1);
    if (idx_i == 5'd0) begin
      byte_o = SYNC_BYTE;
    end else if (idx_i <= 5'd16) begin
      // bit offset = 32*candidate + 8*(3-byte), so byte 0 of each tally is its MSB
      byte_o = snap_i[{pos[3:2], ~pos[1:0], 3'b000} +: 8];
    end else if (idx_i == 5'd17) begin
      byte_o = {5'b00000, winner_i};
    end else if (idx_i == 5'd18) begin
      byte_o = csum_i;
    end
  end

endmodule

// File: rtl/vote_tally_reader.sv
// rtl/vote_tally_reader.sv - snapshots four tallies, picks a unique winner, streams a 19-byte frame
module vote_tally_reader
  import vote_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       start,
  input  logic [NUM_CAND*VOTE_W-1:0] votes_in,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [2:0]                 winner,
  output logic                       tie
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  reader_state_e              state_q, state_d;
  logic [NUM_CAND*VOTE_W-1:0] snap_q, snap_d;
  logic [1:0]                 cand_q, cand_d;
  logic [VOTE_W-1:0]          max_q, max_d;
  logic [2:0]                 best_q, best_d;
  logic                       tie_run_q, tie_run_d;
  logic [2:0]                 winner_q, winner_d;
  logic                       tie_q, tie_d;
  logic [4:0]                 idx_q, idx_d;
  logic [7:0]                 csum_q, csum_d;
  logic [7:0]                 mux_byte;
  logic [VOTE_W-1:0]          cur_vote;

  tally_frame_mux #(.SYNC_BYTE(SYNC_BYTE)) u_mux (
    .snap_i   (snap_q),
    .winner_i (winner_q),
    .csum_i   (csum_q),
    .idx_i    (idx_q),
    .byte_o   (mux_byte)
  );

  assign cur_vote = snap_q[{cand_q, 5'b00000} +: VOTE_W];

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cand_d    = cand_q;
    max_d     = max_q;
    best_d    = best_q;
    tie_run_d = tie_run_q;
    winner_d  = winner_q;
    tie_d     = tie_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    case (state_q)
      IDLE: begin
        if (start && mode == MODE_DISPLAY) state_d = CAPTURE;
      end
      CAPTURE: begin
        snap_d  = votes_in;
        csum_d  = 8'h00;
        idx_d   = 5'd0;
        cand_d  = 2'd0;
        state_d = COMPARE;
      end
      COMPARE: begin
        cand_d = cand_q + 2'd1;
        // tie_run tracks whether the running maximum is shared; a strictly larger tally clears it
        if (cand_q == 2'd0 || cur_vote > max_q) begin
          max_d     = cur_vote;
          best_d    = {1'b0, cand_q} + 3'd1;
          tie_run_d = 1'b0;
        end else if (cur_vote == max_q) begin
          tie_run_d = 1'b1;
        end
        if (cand_q == 2'd3) begin
          winner_d = tie_run_d ? 3'd0 : best_d;
          tie_d    = tie_run_d;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            csum_d = csum_q ^ mux_byte;
            idx_d  = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      cand_q    <= 2'd0;
      max_q     <= '0;
      best_q    <= 3'd0;
      tie_run_q <= 1'b0;
      winner_q  <= 3'd0;
      tie_q     <= 1'b0;
      idx_q     <= 5'd0;
      csum_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      cand_q    <= cand_d;
      max_q     <= max_d;
      best_q    <= best_d;
      tie_run_q <= tie_run_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = out_valid ? mux_byte : 8'h00;
  assign busy      = (state_q != IDLE);
  assign winner    = winner_q;
  assign tie       = tie_q;

endmodule

// File: tb/tb_vote_tally_reader.sv
// tb/tb_vote_tally_reader.sv - directed self-checking bench for vote_tally_reader
module tb_vote_tally_reader;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         start = 1'b0;
  logic [127:0] votes_in = '0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic [2:0]   winner;
  logic         tie;

  int         pass_cnt = 0;
  int         tot_cnt = 0;
  logic [7:0] rx [0:31];
  logic       rx_l [0:31];
  int         rx_n;
  int         lat;

  vote_tally_reader #(.SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .votes_in(votes_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .winner(winner), .tie(tie)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(input logic [127:0] v, input logic [2:0] w,
                                          input logic [7:0] ck, input int k);
    int c;
    int b;
    if (k == 0) return 8'hA5;
    if (k <= 16) begin
      c = (k - 1) / 4;
      b = (k - 1) % 4;
      return v[32*c + 8*(3-b) +: 8];
    end
    if (k == 17) return {5'b00000, w};
    return ck;
  endfunction

  task automatic kick(input logic [127:0] v);
    out_ready = 1'b0;
    votes_in  = v;
    mode      = 2'b11;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic collect(input bit bp, input bit hold, input bit chg, input int max_n);
    logic [7:0] prev_d, d;
    logic       prev_l, l, xfer, stalled, done;
    int         cyc;
    rx_n = 0; stalled = 1'b0; done = 1'b0; cyc = 0; prev_d = 8'h00; prev_l = 1'b0;
    while (!done && rx_n < max_n && cyc < 400) begin
      if (stalled) begin
        if ({out_valid, out_last, out_data} !== {1'b1, prev_l, prev_d})
          $display("FAIL stall_hold: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   out_valid, out_last, out_data, prev_l, prev_d);
        else pass_cnt++;
        tot_cnt++;
      end
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (hold) start = 1'b1;
      xfer = out_valid && out_ready;
      d = out_data;
      l = out_last;
      stalled = out_valid && !out_ready;
      prev_d = d;
      prev_l = l;
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        rx[rx_n] = d;
        rx_l[rx_n] = l;
        rx_n++;
        if (l) done = 1'b1;
        if (chg) begin
          votes_in = {128{1'b1}};
          mode = 2'b00;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 400) begin
      $display("FAIL collect_timeout: got %0d bytes in %0d cycles want completion", rx_n, cyc);
      tot_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({out_valid, out_last, busy, out_data, winner, tie} !== 15'd0)
      $display("FAIL reset_state: got v=%b l=%b b=%b d=%h w=%0d t=%b want all 0",
               out_valid, out_last, busy, out_data, winner, tie);
    else pass_cnt++;
    tot_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [127:0] v;
    v = {32'd4, 32'd3, 32'd2, 32'd1};
    kick(v);
    if (lat !== 6) $display("FAIL basic_latency: got %0d want 6", lat); else pass_cnt++;
    tot_cnt++;
    collect(1'b0, 1'b0, 1'b0, 19);
    if (rx_n !== 19) $display("FAIL basic_len: got %0d want 19", rx_n); else pass_cnt++;
    tot_cnt++;
    for (int k = 0; k < 19 && k < rx_n; k++) begin
      if ({rx_l[k], rx[k]} !== {k == 18, exp_byte(v, 3'd4, 8'hA5, k)})
        $display("FAIL basic_byte%0d: got l=%b d=%h want l=%b d=%h", k, rx_l[k], rx[k],
                 k == 18, exp_byte(v, 3'd4, 8'hA5, k));
      else pass_cnt++;
      tot_cnt++;
    end
    if ({winner, tie} !== {3'd4, 1'b0}) $display("FAIL basic_winner: got w=%0d t=%b want w=4 t=0", winner, tie);
    else pass_cnt++;
    tot_cnt++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL basic_idle_after: got v=%b b=%b want 0 0", out_valid, busy);
    else pass_cnt++;
    tot_cnt++;
  endtask

  task automatic test_tie_and_snapshot();
    logic [127:0] v;
    v = {32'd0, 32'd9, 32'd9, 32'd7};
    kick(v);
    collect(1'b0, 1'b0, 1'b1, 19);
    if (rx_n !== 19) $display("FAIL tie_len: got %0d want 19", rx_n); else pass_cnt++;
    tot_cnt++;
    for (int k = 0; k < 19 && k < rx_n; k++) begin
      if ({rx_l[k], rx[k]} !== {k == 18, exp_byte(v, 3'd0, 8'hA2, k)})
        $display("FAIL tie_byte%0d: got l=%b d=%h want l=%b d=%h", k, rx_l[k], rx[k],
                 k == 18, exp_byte(v, 3'd0, 8'hA2, k));
      else pass_cnt++;
      tot_cnt++;
    end
    if ({winner, tie} !== {3'd0, 1'b1}) $display("FAIL tie_winner: got w=%0d t=%b want w=0 t=1", winner, tie);
    else pass_cnt++;
    tot_cnt++;
  endtask

  task automatic test_backpressure();
    logic [127:0] v;
    v = {32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF};
    kick(v);
    if (lat !== 6) $display("FAIL bp_latency: got %0d want 6", lat); else pass_cnt++;
    tot_cnt++;
    collect(1'b1, 1'b0, 1'b0, 19);
    if (rx_n !== 19) $display("FAIL bp_len: got %0d want 19", rx_n); else pass_cnt++;
    tot_cnt++;
    for (int k = 0; k < 19 && k < rx_n; k++) begin
      if ({rx_l[k], rx[k]} !== {k == 18, exp_byte(v, 3'd1, 8'hA7, k)})
        $display("FAIL bp_byte%0d: got l=%b d=%h want l=%b d=%h", k, rx_l[k], rx[k],
                 k == 18, exp_byte(v, 3'd1, 8'hA7, k));
      else pass_cnt++;
      tot_cnt++;
    end
    if ({winner, tie} !== {3'd1, 1'b0}) $display("FAIL bp_winner: got w=%0d t=%b want w=1 t=0", winner, tie);
    else pass_cnt++;
    tot_cnt++;
  endtask

  task automatic test_gating();
    bit seen;
    mode = 2'b01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy || out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (seen !== 1'b0) $display("FAIL gate_mode01: got activity=1 want 0"); else pass_cnt++;
    tot_cnt++;
    kick({32'd4, 32'd3, 32'd2, 32'd1});
    collect(1'b0, 1'b1, 1'b0, 40);
    if ({rx_n, rx[18]} !== {32'd19, 8'hA5}) $display("FAIL gate_busy_frame: got n=%0d ck=%h want n=19 ck=a5", rx_n, rx[18]);
    else pass_cnt++;
    tot_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy || out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (seen !== 1'b0) $display("FAIL gate_start_on_last: got activity=1 want 0"); else pass_cnt++;
    tot_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] v;
    bit seen;
    kick({32'd4, 32'd3, 32'd2, 32'd1});
    collect(1'b0, 1'b0, 1'b0, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    if ({out_valid, out_last, busy, out_data, winner, tie} !== 15'd0)
      $display("FAIL rst_mid_state: got v=%b l=%b b=%b d=%h w=%0d t=%b want all 0",
               out_valid, out_last, busy, out_data, winner, tie);
    else pass_cnt++;
    tot_cnt++;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy || out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (seen !== 1'b0) $display("FAIL rst_no_resume: got activity=1 want 0"); else pass_cnt++;
    tot_cnt++;
    v = {32'h0102_0304, 32'd0, 32'd0, 32'd0};
    kick(v);
    if (lat !== 6) $display("FAIL rst_new_latency: got %0d want 6", lat); else pass_cnt++;
    tot_cnt++;
    collect(1'b0, 1'b0, 1'b0, 19);
    if (rx_n !== 19) $display("FAIL rst_new_len: got %0d want 19", rx_n); else pass_cnt++;
    tot_cnt++;
    for (int k = 0; k < 19 && k < rx_n; k++) begin
      if ({rx_l[k], rx[k]} !== {k == 18, exp_byte(v, 3'd4, 8'hA5, k)})
        $display("FAIL rst_new_byte%0d: got l=%b d=%h want l=%b d=%h", k, rx_l[k], rx[k],
                 k == 18, exp_byte(v, 3'd4, 8'hA5, k));
      else pass_cnt++;
      tot_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_and_snapshot();
    test_backpressure();
    test_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
